// File: rtl/ls_issue_queue.sv
// ---------------------------------------------------------------------------
// ls_issue_queue
//
// In-order load/store issue queue between dispatch and the memory/LSQ stage.
// It holds up to DEPTH memory instructions in program order in a circular
// buffer, captures source-operand wakeups from the CDB (with a bypass for a
// broadcast that lands in the dispatch cycle), and issues the head once both
// operands are ready and the downstream stage accepts it. Entries squashed by
// branch recovery stay in place as dead entries and drain silently, one per
// cycle, when they reach the head. flush_all empties the queue.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   dispatch ... immed  dispatch request and the instruction's fields
//   stall_hazard        global stall (blocks write, issue and drop)
//   recover/rob_num_rec squash entries whose ROB index matches
//   flush_all           empty the queue (highest priority)
//   complete, RegDest_compl, p_rd_compl   CDB broadcast
//   issue_ready         downstream accepts an issue this cycle
//   issue               head issued this cycle
//   p_rs_out ... mem_wen_out   head fields (combinational from head slot)
//   count, full, empty  occupancy status
// ---------------------------------------------------------------------------
module ls_issue_queue #(
   parameter int DEPTH  = 8,
   parameter int PREG_W = 6,
   parameter int ROB_W  = 4,
   parameter int IMM_W  = 16,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dispatch,
   input  logic [ROB_W-1:0]  rob_num_dp,
   input  logic [PREG_W-1:0] p_rd_new,
   input  logic [PREG_W-1:0] p_rs,
   input  logic [PREG_W-1:0] p_rt,
   input  logic              v_rs,
   input  logic              v_rt,
   input  logic              mem_ren,
   input  logic              mem_wen,
   input  logic [IMM_W-1:0]  immed,
   input  logic              stall_hazard,
   input  logic              recover,
   input  logic [ROB_W-1:0]  rob_num_rec,
   input  logic              flush_all,
   input  logic              complete,
   input  logic              RegDest_compl,
   input  logic [PREG_W-1:0] p_rd_compl,
   input  logic              issue_ready,
   output logic              issue,
   output logic [PREG_W-1:0] p_rs_out,
   output logic [PREG_W-1:0] p_rt_out,
   output logic [PREG_W-1:0] p_rd_out,
   output logic [IMM_W-1:0]  immed_out,
   output logic              RegDest_out,
   output logic              mem_ren_out,
   output logic              mem_wen_out,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   // Entry storage
   logic              valid_reg [DEPTH];
   logic              ren_reg   [DEPTH];
   logic              wen_reg   [DEPTH];
   logic [ROB_W-1:0]  rob_reg   [DEPTH];
   logic [PREG_W-1:0] prd_reg   [DEPTH];
   logic [PREG_W-1:0] prs_reg   [DEPTH];
   logic              vrs_reg   [DEPTH];
   logic [PREG_W-1:0] prt_reg   [DEPTH];
   logic              vrt_reg   [DEPTH];
   logic [IMM_W-1:0]  imm_reg   [DEPTH];

   logic              valid_next [DEPTH];
   logic              ren_next   [DEPTH];
   logic              wen_next   [DEPTH];
   logic [ROB_W-1:0]  rob_next   [DEPTH];
   logic [PREG_W-1:0] prd_next   [DEPTH];
   logic [PREG_W-1:0] prs_next   [DEPTH];
   logic              vrs_next   [DEPTH];
   logic [PREG_W-1:0] prt_next   [DEPTH];
   logic              vrt_next   [DEPTH];
   logic [IMM_W-1:0]  imm_next   [DEPTH];

   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg;

   logic write, pop, drop, cdb_hit;
   logic head_valid, head_ren, head_wen, head_live, head_dead;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;

   assign cdb_hit = complete & RegDest_compl;
   assign write   = dispatch & (mem_ren | mem_wen) & ~full & ~stall_hazard
                    & ~recover & ~flush_all;

   assign head_valid = valid_reg[head_reg];
   assign head_ren   = ren_reg[head_reg];
   assign head_wen   = wen_reg[head_reg];
   assign head_live  = head_valid & (head_ren | head_wen)
                       & vrs_reg[head_reg] & vrt_reg[head_reg];
   // A squashed entry keeps its slot (valid with no type) until it reaches
   // the head; it is then popped without being presented as an issue.
   assign head_dead  = head_valid & ~head_ren & ~head_wen;

   assign issue = head_live & issue_ready & ~stall_hazard & ~recover & ~flush_all;
   assign drop  = head_dead & ~stall_hazard & ~flush_all;
   assign pop   = issue | drop;

   assign p_rs_out    = prs_reg[head_reg];
   assign p_rt_out    = prt_reg[head_reg];
   assign p_rd_out    = prd_reg[head_reg];
   assign immed_out   = imm_reg[head_reg];
   assign RegDest_out = head_ren;
   assign mem_ren_out = head_ren;
   assign mem_wen_out = head_wen;

   // Per-entry next-state. Write and pop never hit the same slot: that would
   // need head==tail with a valid head (full), and write is blocked when full.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic wr_here, pop_here, wake_rs, wake_rt, squash_here;

         assign wr_here     = write & (tail_reg == PTR_W'(gi));
         assign pop_here    = pop & (head_reg == PTR_W'(gi));
         assign wake_rs     = cdb_hit & valid_reg[gi] & (prs_reg[gi] == p_rd_compl);
         assign wake_rt     = cdb_hit & valid_reg[gi] & (prt_reg[gi] == p_rd_compl);
         assign squash_here = recover & valid_reg[gi] & (rob_reg[gi] == rob_num_rec);

         assign valid_next[gi] = flush_all ? 1'b0 :
                                 wr_here   ? 1'b1 :
                                 pop_here  ? 1'b0 : valid_reg[gi];
         assign ren_next[gi]   = wr_here ? mem_ren : (squash_here ? 1'b0 : ren_reg[gi]);
         assign wen_next[gi]   = wr_here ? mem_wen : (squash_here ? 1'b0 : wen_reg[gi]);
         assign rob_next[gi]   = wr_here ? rob_num_dp : rob_reg[gi];
         assign prd_next[gi]   = wr_here ? p_rd_new   : prd_reg[gi];
         assign prs_next[gi]   = wr_here ? p_rs       : prs_reg[gi];
         assign prt_next[gi]   = wr_here ? p_rt       : prt_reg[gi];
         assign imm_next[gi]   = wr_here ? immed      : imm_reg[gi];
         // Bypass: a broadcast in the dispatch cycle is captured directly.
         assign vrs_next[gi]   = wr_here ? (v_rs | (cdb_hit & (p_rs == p_rd_compl)))
                                         : (vrs_reg[gi] | wake_rs);
         assign vrt_next[gi]   = wr_here ? (v_rt | (cdb_hit & (p_rt == p_rd_compl)))
                                         : (vrt_reg[gi] | wake_rt);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i] <= 1'b0;
            ren_reg[i]   <= 1'b0;
            wen_reg[i]   <= 1'b0;
            rob_reg[i]   <= '0;
            prd_reg[i]   <= '0;
            prs_reg[i]   <= '0;
            vrs_reg[i]   <= 1'b0;
            prt_reg[i]   <= '0;
            vrt_reg[i]   <= 1'b0;
            imm_reg[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_reg[i] <= valid_next[i];
            ren_reg[i]   <= ren_next[i];
            wen_reg[i]   <= wen_next[i];
            rob_reg[i]   <= rob_next[i];
            prd_reg[i]   <= prd_next[i];
            prs_reg[i]   <= prs_next[i];
            vrs_reg[i]   <= vrs_next[i];
            prt_reg[i]   <= prt_next[i];
            vrt_reg[i]   <= vrt_next[i];
            imm_reg[i]   <= imm_next[i];
         end
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush_all) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (write) tail_reg <= tail_reg + PTR_W'(1);
         if (pop)   head_reg <= head_reg + PTR_W'(1);
         case ({write, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Bench for ls_issue_queue: instructions expected to issue are pushed to a
// scoreboard queue at dispatch and popped/compared when issue is observed.
module tb_ls_issue_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        dispatch;
   logic [3:0]  rob_num_dp;
   logic [5:0]  p_rd_new, p_rs, p_rt;
   logic        v_rs, v_rt, mem_ren, mem_wen;
   logic [15:0] immed;
   logic        stall_hazard, recover, flush_all;
   logic [3:0]  rob_num_rec;
   logic        complete, RegDest_compl;
   logic [5:0]  p_rd_compl;
   logic        issue_ready;
   logic        issue;
   logic [5:0]  p_rs_out, p_rt_out, p_rd_out;
   logic [15:0] immed_out;
   logic        RegDest_out, mem_ren_out, mem_wen_out;
   logic [3:0]  count;
   logic        full, empty;

   ls_issue_queue #(.DEPTH(8), .PREG_W(6), .ROB_W(4), .IMM_W(16)) dut (
      .clk(clk), .rst(rst), .dispatch(dispatch), .rob_num_dp(rob_num_dp),
      .p_rd_new(p_rd_new), .p_rs(p_rs), .p_rt(p_rt), .v_rs(v_rs), .v_rt(v_rt),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .immed(immed),
      .stall_hazard(stall_hazard), .recover(recover), .rob_num_rec(rob_num_rec),
      .flush_all(flush_all), .complete(complete), .RegDest_compl(RegDest_compl),
      .p_rd_compl(p_rd_compl), .issue_ready(issue_ready), .issue(issue),
      .p_rs_out(p_rs_out), .p_rt_out(p_rt_out), .p_rd_out(p_rd_out),
      .immed_out(immed_out), .RegDest_out(RegDest_out), .mem_ren_out(mem_ren_out),
      .mem_wen_out(mem_wen_out), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  prd;
      logic [5:0]  prs;
      logic [15:0] imm;
      logic        wen;
   } exp_t;

   exp_t exp_q[$];
   int   checks_cnt   = 0;
   int   failures_cnt = 0;
   logic last_issue;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks_cnt++;
      if (got !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One cycle: sample issue on the falling edge (scoreboard pop/compare),
   // then let the rising edge happen and return 1 time unit after it.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      last_issue = issue;
      if (issue) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_issue", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("issue prd=%0d prs=%0d imm=%0d wen=%0d", p_rd_out, p_rs_out, immed_out, mem_wen_out);
            check_eq("issue_prd", p_rd_out, e.prd);
            check_eq("issue_prs", p_rs_out, e.prs);
            check_eq("issue_imm", immed_out, e.imm);
            check_eq("issue_wen", mem_wen_out, e.wen);
            check_eq("issue_ren", mem_ren_out, !e.wen);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dispatch = 0; complete = 0; RegDest_compl = 0; recover = 0;
      flush_all = 0; stall_hazard = 0;
   endtask

   task automatic set_dp(input logic [5:0] prd, input logic [5:0] prs, input logic vs,
                         input logic [5:0] prt, input logic vt, input logic wen,
                         input logic [3:0] rob);
      dispatch = 1; p_rd_new = prd; p_rs = prs; v_rs = vs; p_rt = prt; v_rt = vt;
      mem_wen = wen; mem_ren = !wen; rob_num_dp = rob; immed = {10'd0, prd} + 16'd100;
   endtask

   task automatic push(input logic [5:0] prd, input logic [5:0] prs, input logic wen);
      exp_t e;
      e.prd = prd; e.prs = prs; e.wen = wen; e.imm = {10'd0, prd} + 16'd100;
      exp_q.push_back(e);
   endtask

   int sent;

   initial begin
      rst = 0; idle(); issue_ready = 0;
      rob_num_dp = 0; p_rd_new = 0; p_rs = 0; p_rt = 0; v_rs = 0; v_rt = 0;
      mem_ren = 0; mem_wen = 0; immed = 0; rob_num_rec = 0; p_rd_compl = 0;
      #12;
      check_eq("rst_count", count, 0);
      check_eq("rst_empty", empty, 1);
      check_eq("rst_full", full, 0);
      check_eq("rst_issue", issue, 0);
      check_eq("rst_prd_out", p_rd_out, 0);
      @(posedge clk); #1; rst = 1;

      // Fill with 8 ready loads while downstream is not ready.
      for (int i = 0; i < 8; i++) begin
         set_dp(6'(10 + i), 6'(i), 1, 6'(20 + i), 1, 0, 4'(i));
         push(6'(10 + i), 6'(i), 0);
         tick();
      end
      check_eq("fill_count", count, 8);
      check_eq("fill_full", full, 1);
      set_dp(6'd63, 6'd1, 1, 6'd1, 1, 0, 4'd9);
      tick();
      check_eq("ninth_ignored", count, 8);
      dispatch = 0; issue_ready = 1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("drain_issue", last_issue, 1);
         check_eq("drain_not_full", full, 0);
      end
      check_eq("drain_empty", empty, 1);

      // CDB wakeup of rs, then rt.
      set_dp(6'd30, 6'd5, 0, 6'd7, 0, 0, 4'd1);
      push(6'd30, 6'd5, 0);
      tick(); dispatch = 0;
      tick(); check_eq("wait_no_issue", last_issue, 0);
      complete = 1; RegDest_compl = 1; p_rd_compl = 6'd5;
      tick(); check_eq("wake_rs_cycle", last_issue, 0);
      p_rd_compl = 6'd7;
      tick(); check_eq("rt_still_pending", last_issue, 0);
      complete = 0;
      tick(); check_eq("wake_issue", last_issue, 1);

      // Broadcast without RegDest must not wake.
      set_dp(6'd31, 6'd5, 0, 6'd2, 1, 0, 4'd2);
      push(6'd31, 6'd5, 0);
      tick(); dispatch = 0;
      complete = 1; RegDest_compl = 0; p_rd_compl = 6'd5;
      tick(); complete = 0;
      for (int k = 0; k < 4; k++) begin
         tick(); check_eq("no_regdest_no_issue", last_issue, 0);
      end
      complete = 1; RegDest_compl = 1; p_rd_compl = 6'd5;
      tick(); complete = 0;
      tick(); check_eq("late_wake_issue", last_issue, 1);

      // Dispatch bypass: store with both tags broadcast in the dispatch cycle.
      set_dp(6'd40, 6'd9, 0, 6'd9, 0, 1, 4'd3);
      push(6'd40, 6'd9, 1);
      complete = 1; RegDest_compl = 1; p_rd_compl = 6'd9;
      tick(); idle();
      tick(); check_eq("bypass_issue", last_issue, 1);
      check_eq("bypass_empty", empty, 1);

      // Squash ROB 3 at the head; it drops silently, then ROB 4 issues.
      issue_ready = 0;
      for (int i = 0; i < 3; i++) begin
         set_dp(6'(50 + i), 6'd1, 1, 6'd1, 1, 0, 4'(3 + i));
         if (i != 0) push(6'(50 + i), 6'd1, 0);
         tick();
      end
      dispatch = 0; recover = 1; rob_num_rec = 4'd3;
      tick(); recover = 0;
      check_eq("squash_count_kept", count, 3);
      issue_ready = 1;
      tick(); check_eq("drop_no_issue", last_issue, 0);
      check_eq("drop_count", count, 2);
      tick(); check_eq("rob4_issue", last_issue, 1);
      tick(); check_eq("rob5_issue", last_issue, 1);
      check_eq("squash_empty", empty, 1);

      // Interleaved dispatch/issue across pointer wrap.
      sent = 0;
      for (int cyc = 0; cyc < 300 && (sent < 20 || exp_q.size() != 0); cyc++) begin
         issue_ready = 1'($urandom_range(0, 1));
         if (sent < 20 && $urandom_range(0, 3) != 0) begin
            set_dp(6'(sent), 6'(sent + 1), 1, 6'd3, 1, 1'(sent % 3 == 0), 4'(sent));
            if (!full) begin
               push(6'(sent), 6'(sent + 1), 1'(sent % 3 == 0));
               sent++;
            end
         end else begin
            dispatch = 0;
         end
         tick();
         check_eq("wrap_count", count, exp_q.size());
         check_eq("wrap_le_depth", int'(count <= 4'd8), 1);
      end
      dispatch = 0;
      check_eq("wrap_all_sent", sent, 20);
      check_eq("wrap_drained", exp_q.size(), 0);

      // Flush with 5 entries while stalled.
      issue_ready = 0;
      for (int i = 0; i < 5; i++) begin
         set_dp(6'(20 + i), 6'd1, 1, 6'd1, 1, 0, 4'(i));
         tick();
      end
      dispatch = 0;
      check_eq("pre_flush_count", count, 5);
      stall_hazard = 1; flush_all = 1;
      tick(); idle(); issue_ready = 1;
      check_eq("flush_count", count, 0);
      check_eq("flush_empty", empty, 1);
      tick(); check_eq("flush_no_issue", last_issue, 0);

      // Asynchronous reset mid-operation.
      issue_ready = 0;
      for (int i = 0; i < 2; i++) begin
         set_dp(6'(33 + i), 6'd1, 1, 6'd1, 1, 0, 4'(i));
         tick();
      end
      dispatch = 0;
      check_eq("pre_rst_count", count, 2);
      #2 rst = 0;
      #1;
      check_eq("async_rst_count", count, 0);
      check_eq("async_rst_empty", empty, 1);
      check_eq("async_rst_prd", p_rd_out, 0);
      @(posedge clk); #1; rst = 1; issue_ready = 1;
      tick(); check_eq("post_rst_no_issue", last_issue, 0);
      check_eq("final_queue", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule

// File: doc/ls_issue_queue.md
# ls_issue_queue

Parametrised in-order load/store issue queue for the out-of-order pipeline, sitting between dispatch and the memory/LSQ stage. It holds up to DEPTH memory instructions in program order and captures operand wakeups from the CDB. The head issues only when both source operands are valid and the downstream stage accepts it. Over the 4-entry load/store station it adds configurable depth and widths, a downstream ready handshake, CDB bypass at dispatch, silent draining of squashed entries and a full flush.

## Interface
- DEPTH, 8, entry count; power of two, at least 2
- PREG_W, 6, physical register tag width
- ROB_W, 4, ROB index width
- IMM_W, 16, immediate width
- CNT_W, $clog2(DEPTH+1), occupancy counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dispatch  in  1  dispatch request
- rob_num_dp  in  ROB_W  ROB index of the dispatched instruction
- p_rd_new, p_rs, p_rt  in  PREG_W  destination and source tags
- v_rs, v_rt  in  1  source operand valid at dispatch
- mem_ren, mem_wen  in  1  load / store type
- immed  in  IMM_W  offset
- stall_hazard  in  1  global stall
- recover  in  1  branch recovery; squash entries whose ROB index matches
- rob_num_rec  in  ROB_W  ROB index to squash
- flush_all  in  1  exception flush; empty the queue
- complete  in  1  CDB broadcast valid
- RegDest_compl  in  1  the broadcast writes a register
- p_rd_compl  in  PREG_W  broadcast tag
- issue_ready  in  1  downstream can accept an issue this cycle
- issue  out  1  head issued this cycle
- p_rs_out, p_rt_out, p_rd_out  out  PREG_W  head tags
- immed_out  out  IMM_W  head immediate
- RegDest_out, mem_ren_out  out  1  head is a load
- mem_wen_out  out  1  head is a store
- count  out  CNT_W  occupancy
- full, empty  out  1  count==DEPTH / count==0

## Operation
- Each entry holds: valid, ren, wen, rob, prd, prs, vrs, prt, vrt, imm.
- Head and tail are log2(DEPTH)-bit pointers that wrap modulo DEPTH.
- write = dispatch & (mem_ren|mem_wen) & !full & !stall_hazard & !recover & !flush_all.
  - Dispatch with neither ren nor wen set is ignored.
  - A write stores the entry at tail and advances tail.
- Wakeup: complete & RegDest_compl & valid & (prs==p_rd_compl) sets vrs; the same rule on prt sets vrt.
- Dispatch bypass: a writing entry stores vrs = v_rs | (complete & RegDest_compl & p_rs==p_rd_compl). The same rule applies to vrt.
- Squash: recover & valid & rob==rob_num_rec clears ren and wen. The entry stays valid as a dead entry.
- A recover in the same cycle as a write is invalid, because write is already blocked by recover.
- head_live = valid & (ren|wen) & vrs & vrt.
- head_dead = valid & !ren & !wen.
- issue = head_live & issue_ready & !stall_hazard & !recover & !flush_all.
- drop = head_dead & !stall_hazard & !flush_all.
  - A drop pops the head without asserting issue.
- pop = issue | drop. A pop clears valid at head and advances head.
- count updates by +write −pop; a simultaneous write and pop leaves count unchanged.
- flush_all has priority over everything:
  - clears all valid bits
  - sets head = tail = 0 and count = 0
- Head outputs are combinational from the head slot. They are don't-care when empty, but are zero after reset.

## Timing
- Reset values:
  - all entries and outputs 0
  - empty = 1, full = 0, count = 0, issue = 0
- Dispatch at edge N with operands valid: issue may assert in cycle N+1 (same cycle issue_ready is seen).
- Wakeup at edge N: a head waiting on that tag can issue in cycle N+1.
- Wakeup coincident with dispatch is captured through the bypass; no cycle is lost.
- Squash at edge N: the dead head drops in cycle N+1, one entry per cycle.
- full deasserts the cycle after a pop.
- When full, a simultaneous write is blocked even if a pop occurs that cycle.
- Reset asserted mid-operation clears the queue asynchronously.

## Test plan
- Reset, then 8 loads with v_rs=v_rt=1 and issue_ready=0 -> count=8, full=1, 9th dispatch ignored. Then issue_ready=1 -> issue on 8 consecutive cycles, in order, with p_rd_out matching the dispatch order.
- Head load with vrs=0 on prs=5; CDB complete p_rd_compl=5, RegDest_compl=1 at edge N -> issue=1 in cycle N+1. Repeat with RegDest_compl=0 -> issue never asserts.
- Dispatch a store with p_rs=9, v_rs=0 in the same cycle as complete p_rd_compl=9 -> store issues the next cycle.
- Queue holds ROB 3, 4, 5; recover with rob_num_rec=3 -> ROB 3 drops silently (issue=0, count 3→2), then ROB 4 issues.
- Tail wraps past DEPTH−1 with interleaved dispatch and issue over 20 instructions -> order preserved, count never exceeds 8.
- flush_all with 5 entries while stall_hazard=1 -> next cycle count=0, empty=1, issue=0.
